// File: rtl/pe_pkg.sv
// Shared types and helpers for the pe_dot_engine dot-product processing element.
package pe_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned IDX_W     = $clog2(DEPTH_DEF);
  localparam int unsigned ACC_MAX_W = 128;

  // Clamp value for an acc_w-bit accumulator; neg selects the signed minimum.
  function automatic logic [ACC_MAX_W-1:0] sat_limit(input int unsigned acc_w,
                                                     input bit          is_signed,
                                                     input bit          neg);
    logic [ACC_MAX_W-1:0] mask;
    mask = (ACC_MAX_W'(1) << acc_w) - ACC_MAX_W'(1);
    if (!is_signed) begin
      return mask;
    end
    return neg ? (mask ^ (mask >> 1)) : (mask >> 1);
  endfunction

endpackage

// File: rtl/pe_dot_engine_if.sv
// Load, start and result handshake bundle between the array controller and one lane.
interface pe_dot_engine_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ACC_W  = 64,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned LEN_W = $clog2(DEPTH) + 1;

  logic              LOAD_VALID;
  logic              LOAD_READY;
  logic              LOAD_SEL;
  logic              LOAD_CLR;
  logic [DATA_W-1:0] LOAD_DATA;
  logic [LEN_W-1:0]  LEN;
  logic              ACCUM;
  logic              START;
  logic              BUSY;
  logic              ERR;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [ACC_W-1:0]  OUT_DATA;
  logic              OVF;

  modport master (
    output LOAD_VALID, LOAD_SEL, LOAD_CLR, LOAD_DATA, LEN, ACCUM, START, OUT_READY,
    input  LOAD_READY, BUSY, ERR, OUT_VALID, OUT_DATA, OVF
  );

  modport slave (
    input  LOAD_VALID, LOAD_SEL, LOAD_CLR, LOAD_DATA, LEN, ACCUM, START, OUT_READY,
    output LOAD_READY, BUSY, ERR, OUT_VALID, OUT_DATA, OVF
  );

endinterface

// File: rtl/pe_vec_rf.sv
// One operand vector: DEPTH x DATA_W storage with a wrapping write pointer and
// a combinational read port. Storage is deliberately not reset.
module pe_vec_rf #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     WE,
  input  logic                     CLR,
  input  logic [DATA_W-1:0]        WDATA,
  input  logic [$clog2(DEPTH)-1:0] RADDR,
  output logic [DATA_W-1:0]        RDATA
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wp_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wp_q <= '0;
    end else if (CLR) begin
      wp_q <= '0;
    end else if (WE) begin
      wp_q <= wp_q + PTR_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (WE && !CLR) begin
      mem_q[wp_q] <= WDATA;
    end
  end

  assign RDATA = mem_q[RADDR];

endmodule

// File: rtl/pe_dot_engine.sv
// Dot-product processing element: two operand vectors, a run-length-selected MAC
// loop into a wide accumulator, with optional signed and saturating arithmetic.
module pe_dot_engine
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ACC_W  = 64,
  parameter int unsigned DEPTH  = 16,
  parameter bit          SIGNED = 1'b0,
  parameter bit          SAT    = 1'b0
) (
  input logic           CLK,
  input logic           RST,
  pe_dot_engine_if.slave bus
);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LEN_W  = PTR_W + 1;
  localparam int unsigned PROD_W = 2 * DATA_W;

  localparam logic [ACC_MAX_W-1:0] SAT_HI_FULL = sat_limit(ACC_W, SIGNED, 1'b0);
  localparam logic [ACC_MAX_W-1:0] SAT_LO_FULL = sat_limit(ACC_W, SIGNED, 1'b1);
  localparam logic [ACC_W-1:0]     SAT_HI      = SAT_HI_FULL[ACC_W-1:0];
  localparam logic [ACC_W-1:0]     SAT_LO      = SAT_LO_FULL[ACC_W-1:0];

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  pc_q;
  logic [LEN_W-1:0]  len_q;
  logic [ACC_W-1:0]  acc_q;
  logic              ovf_q;
  logic              sat_q;
  logic              err_q;

  logic              len_ok;
  logic              last;
  logic              start_go;
  logic              start_bad;
  logic              step;
  logic              load_go;
  logic              clr;
  logic              we_a;
  logic              we_b;
  logic [DATA_W-1:0] a_rd;
  logic [DATA_W-1:0] b_rd;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  prod_x;
  logic [ACC_W:0]    sum_w;
  logic [ACC_W-1:0]  sum;
  logic [ACC_W-1:0]  lim;
  logic              ovf_now;

  assign len_ok = (bus.LEN != '0) && (bus.LEN <= LEN_W'(DEPTH));
  assign last   = ({1'b0, pc_q} == (len_q - LEN_W'(1)));

  always_comb begin
    state_d   = state_q;
    start_go  = 1'b0;
    start_bad = 1'b0;
    step      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.START) begin
          if (len_ok) begin
            start_go = 1'b1;
            state_d  = RUN;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.OUT_READY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // An accepted START takes the same edge as any offered load, so the load loses.
  assign clr     = (state_q == IDLE) && bus.LOAD_CLR && !start_go;
  assign load_go = (state_q == IDLE) && bus.LOAD_VALID && !bus.LOAD_CLR && !start_go;
  assign we_a    = load_go && bus.LOAD_SEL;
  assign we_b    = load_go && !bus.LOAD_SEL;

  pe_vec_rf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_rf_a (
    .CLK   (CLK),
    .RST   (RST),
    .WE    (we_a),
    .CLR   (clr),
    .WDATA (bus.LOAD_DATA),
    .RADDR (pc_q),
    .RDATA (a_rd)
  );

  pe_vec_rf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_rf_b (
    .CLK   (CLK),
    .RST   (RST),
    .WE    (we_b),
    .CLR   (clr),
    .WDATA (bus.LOAD_DATA),
    .RADDR (pc_q),
    .RDATA (b_rd)
  );

  always_comb begin
    prod   = '0;
    prod_x = '0;
    if (SIGNED) begin
      prod   = $signed({{DATA_W{a_rd[DATA_W-1]}}, a_rd}) *
               $signed({{DATA_W{b_rd[DATA_W-1]}}, b_rd});
      prod_x = ACC_W'($signed(prod));
    end else begin
      prod   = {{DATA_W{1'b0}}, a_rd} * {{DATA_W{1'b0}}, b_rd};
      prod_x = ACC_W'(prod);
    end
  end

  always_comb begin
    sum_w = {1'b0, acc_q} + {1'b0, prod_x};
    sum   = sum_w[ACC_W-1:0];
    if (SIGNED) begin
      ovf_now = (acc_q[ACC_W-1] == prod_x[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    end else begin
      ovf_now = sum_w[ACC_W];
    end
    // Signed overflow only happens with matching operand signs, so acc's sign picks the rail.
    lim = (SIGNED && acc_q[ACC_W-1]) ? SAT_LO : SAT_HI;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= start_bad;
      if (start_go) begin
        len_q <= bus.LEN;
        pc_q  <= '0;
        sat_q <= 1'b0;
        if (!bus.ACCUM) begin
          acc_q <= '0;
          ovf_q <= 1'b0;
        end
      end else if (step) begin
        pc_q <= pc_q + PTR_W'(1);
        // Once clamped, the accumulator is frozen until the next START.
        if (!sat_q) begin
          if (ovf_now) begin
            ovf_q <= 1'b1;
            if (SAT) begin
              acc_q <= lim;
              sat_q <= 1'b1;
            end else begin
              acc_q <= sum;
            end
          end else begin
            acc_q <= sum;
          end
        end
      end
    end
  end

  assign bus.LOAD_READY = (state_q == IDLE);
  assign bus.BUSY       = (state_q != IDLE);
  assign bus.ERR        = err_q;
  assign bus.OUT_VALID  = (state_q == HOLD);
  assign bus.OUT_DATA   = acc_q;
  assign bus.OVF        = ovf_q;

endmodule

// File: tb/tb_pe_dot_engine.sv
// Self-checking bench: a behavioural model of the default unsigned lane compared every
// cycle, plus hand-computed expectations for the default lane and two signed 8/16 lanes.
module tb_pe_dot_engine;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  pe_dot_engine_if #(.DATA_W(32), .ACC_W(64), .DEPTH(16)) bus ();
  pe_dot_engine_if #(.DATA_W(8),  .ACC_W(16), .DEPTH(16)) bs  ();
  pe_dot_engine_if #(.DATA_W(8),  .ACC_W(16), .DEPTH(16)) bw  ();

  pe_dot_engine #(.DATA_W(32), .ACC_W(64), .DEPTH(16), .SIGNED(1'b0), .SAT(1'b0)) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  pe_dot_engine #(.DATA_W(8), .ACC_W(16), .DEPTH(16), .SIGNED(1'b1), .SAT(1'b1)) u_sat (
    .CLK (CLK),
    .RST (RST),
    .bus (bs)
  );

  pe_dot_engine #(.DATA_W(8), .ACC_W(16), .DEPTH(16), .SIGNED(1'b1), .SAT(1'b0)) u_wrap (
    .CLK (CLK),
    .RST (RST),
    .bus (bw)
  );

  // Shared stimulus for the two signed lanes.
  logic       s_valid, s_sel, s_clr, s_accum, s_start, s_ready;
  logic [7:0] s_data;
  logic [4:0] s_len;

  assign bs.LOAD_VALID = s_valid;
  assign bs.LOAD_SEL   = s_sel;
  assign bs.LOAD_CLR   = s_clr;
  assign bs.LOAD_DATA  = s_data;
  assign bs.LEN        = s_len;
  assign bs.ACCUM      = s_accum;
  assign bs.START      = s_start;
  assign bs.OUT_READY  = s_ready;
  assign bw.LOAD_VALID = s_valid;
  assign bw.LOAD_SEL   = s_sel;
  assign bw.LOAD_CLR   = s_clr;
  assign bw.LOAD_DATA  = s_data;
  assign bw.LEN        = s_len;
  assign bw.ACCUM      = s_accum;
  assign bw.START      = s_start;
  assign bw.OUT_READY  = s_ready;

  int n_pass = 0;
  int n_chk  = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Model of the default lane: vectors, pointers, and the visible result.
  logic [31:0] ma [16];
  logic [31:0] mb [16];
  int          mwa, mwb, m_run;
  bit          m_hold, m_err, m_ovf, m_res_ovf;
  logic [63:0] m_acc, m_res;

  task automatic dot(input int len, input bit keep);
    logic [64:0] s;
    logic [63:0] acc;
    bit          o;
    acc = keep ? m_acc : 64'd0;
    o   = keep ? m_ovf : 1'b0;
    for (int i = 0; i < len; i++) begin
      s   = {1'b0, acc} + {1'b0, {32'd0, ma[i]} * {32'd0, mb[i]}};
      acc = s[63:0];
      if (s[64]) o = 1'b1;
    end
    m_res     = acc;
    m_res_ovf = o;
  endtask

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      mwa = 0; mwb = 0; m_run = 0; m_hold = 1'b0; m_err = 1'b0;
      m_acc = '0; m_ovf = 1'b0;
    end else begin
      m_err = 1'b0;
      if (m_run > 0) begin
        m_run--;
        if (m_run == 0) begin
          m_hold = 1'b1;
          m_acc  = m_res;
          m_ovf  = m_res_ovf;
        end
      end else if (m_hold) begin
        if (bus.OUT_READY) m_hold = 1'b0;
      end else if (bus.START && bus.LEN >= 1 && bus.LEN <= 16) begin
        dot(int'(bus.LEN), bus.ACCUM);
        m_run = int'(bus.LEN);
      end else begin
        if (bus.START) m_err = 1'b1;
        if (bus.LOAD_CLR) begin
          mwa = 0; mwb = 0;
        end else if (bus.LOAD_VALID) begin
          if (bus.LOAD_SEL) begin ma[mwa] = bus.LOAD_DATA; mwa = (mwa + 1) % 16; end
          else begin mb[mwb] = bus.LOAD_DATA; mwb = (mwb + 1) % 16; end
        end
      end
    end
  end

  always @(negedge CLK) begin : cmp
    bit idle;
    if (!RST && run_cmp) begin
      idle = (m_run == 0) && !m_hold;
      chk("load_ready", bus.LOAD_READY, idle);
      chk("busy", bus.BUSY, !idle);
      chk("out_valid", bus.OUT_VALID, m_hold);
      chk("err", bus.ERR, m_err);
      if (idle || m_hold) begin
        chk("out_data", bus.OUT_DATA, m_acc);
        chk("ovf", bus.OVF, m_ovf);
      end
    end
  end

  task automatic ld(input bit sel, input logic [31:0] d);
    bus.LOAD_VALID = 1'b1; bus.LOAD_SEL = sel; bus.LOAD_DATA = d;
    @(negedge CLK);
    bus.LOAD_VALID = 1'b0;
  endtask

  task automatic clr_ptrs();
    bus.LOAD_CLR = 1'b1;
    @(negedge CLK);
    bus.LOAD_CLR = 1'b0;
  endtask

  task automatic start(input int len, input bit keep);
    bus.LEN = 5'(len); bus.ACCUM = keep; bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
  endtask

  // Counts the START cycle as cycle 1.
  task automatic wait_valid(input string name, output int cyc);
    cyc = 1;
    while (!bus.OUT_VALID && cyc < 64) begin
      @(negedge CLK);
      cyc++;
    end
    chk({name, "_valid"}, bus.OUT_VALID, 1'b1);
  endtask

  task automatic s_ld(input bit sel, input logic [7:0] d);
    s_valid = 1'b1; s_sel = sel; s_data = d;
    @(negedge CLK);
    s_valid = 1'b0;
  endtask

  task automatic s_run(input int len);
    int n;
    s_len = 5'(len); s_accum = 1'b0; s_start = 1'b1;
    @(negedge CLK);
    s_start = 1'b0;
    n = 0;
    while (!(bs.OUT_VALID && bw.OUT_VALID) && n < 64) begin
      @(negedge CLK);
      n++;
    end
    chk("signed_valid", bs.OUT_VALID && bw.OUT_VALID, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    RST = 1'b1;
    bus.LOAD_VALID = 1'b0; bus.LOAD_SEL = 1'b0; bus.LOAD_CLR = 1'b0; bus.LOAD_DATA = '0;
    bus.LEN = '0; bus.ACCUM = 1'b0; bus.START = 1'b0; bus.OUT_READY = 1'b0;
    s_valid = 1'b0; s_sel = 1'b0; s_clr = 1'b0; s_data = '0; s_len = '0;
    s_accum = 1'b0; s_start = 1'b0; s_ready = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_load_ready", bus.LOAD_READY, 1'b1);
    chk("rst_busy", bus.BUSY, 1'b0);
    chk("rst_err", bus.ERR, 1'b0);
    chk("rst_out_valid", bus.OUT_VALID, 1'b0);
    chk("rst_out_data", bus.OUT_DATA, 64'd0);
    chk("rst_ovf", bus.OVF, 1'b0);
    RST = 1'b0;
    run_cmp = 1'b1;
    @(negedge CLK);

    // A = 1..16, B = 2: sum 2*136.
    clr_ptrs();
    for (int i = 0; i < 16; i++) ld(1'b1, 32'(i + 1));
    for (int i = 0; i < 16; i++) ld(1'b0, 32'd2);
    start(16, 1'b0);
    wait_valid("dot16", cyc);
    chk("dot16_latency", cyc, 17);
    chk("dot16_data", bus.OUT_DATA, 64'd272);
    chk("dot16_ovf", bus.OVF, 1'b0);
    bus.OUT_READY = 1'b1;
    @(negedge CLK);
    chk("dot16_drained", bus.BUSY, 1'b0);

    // Illegal lengths at both ends.
    start(0, 1'b0);
    chk("len0_err", bus.ERR, 1'b1);
    chk("len0_busy", bus.BUSY, 1'b0);
    @(negedge CLK);
    chk("len0_err_once", bus.ERR, 1'b0);
    start(17, 1'b0);
    chk("len17_err", bus.ERR, 1'b1);
    @(negedge CLK);

    // A = B = 1..4: 1+4+9+16.
    clr_ptrs();
    for (int i = 0; i < 4; i++) ld(1'b1, 32'(i + 1));
    for (int i = 0; i < 4; i++) ld(1'b0, 32'(i + 1));
    bus.OUT_READY = 1'b0;
    start(4, 1'b0);
    wait_valid("dot4", cyc);
    chk("dot4_latency", cyc, 5);
    chk("dot4_data", bus.OUT_DATA, 64'd30);
    bus.LEN = 5'd4; bus.ACCUM = 1'b0; bus.START = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      chk("bp_data", bus.OUT_DATA, 64'd30);
      chk("bp_valid", bus.OUT_VALID, 1'b1);
    end
    bus.START = 1'b0; bus.OUT_READY = 1'b1;
    @(negedge CLK);
    chk("bp_released", bus.BUSY, 1'b0);
    start(4, 1'b1);
    wait_valid("accum60", cyc);
    chk("accum60_data", bus.OUT_DATA, 64'd60);
    @(negedge CLK);
    chk("hold_one_cycle", bus.OUT_VALID, 1'b0);
    start(4, 1'b1);
    wait_valid("accum90", cyc);
    chk("accum90_data", bus.OUT_DATA, 64'd90);
    @(negedge CLK);

    // Signed lanes: (-128)^2 * 4 saturates to 32767 / wraps to 0.
    s_clr = 1'b1; @(negedge CLK); s_clr = 1'b0;
    for (int i = 0; i < 4; i++) s_ld(1'b1, 8'h80);
    for (int i = 0; i < 4; i++) s_ld(1'b0, 8'h80);
    s_run(4);
    chk("sat_data", bs.OUT_DATA, 64'd32767);
    chk("sat_ovf", bs.OVF, 1'b1);
    chk("wrap_data", bw.OUT_DATA, 64'd0);
    chk("wrap_ovf", bw.OVF, 1'b1);
    s_ready = 1'b1; @(negedge CLK); s_ready = 1'b0;
    // -3 * 5 = -15, no overflow.
    s_clr = 1'b1; @(negedge CLK); s_clr = 1'b0;
    s_ld(1'b1, 8'hFD);
    s_ld(1'b0, 8'h05);
    s_run(1);
    chk("sneg_sat_data", bs.OUT_DATA, 64'hFFF1);
    chk("sneg_sat_ovf", bs.OVF, 1'b0);
    chk("sneg_wrap_data", bw.OUT_DATA, 64'hFFF1);
    s_ready = 1'b1; @(negedge CLK); s_ready = 1'b0;

    // 17 loads into A: word 17 (117) overwrites A[0]; B[0] = 3, B[1] = 5.
    clr_ptrs();
    for (int i = 0; i < 17; i++) ld(1'b1, 32'(101 + i));
    ld(1'b0, 32'd3);
    ld(1'b0, 32'd5);
    start(1, 1'b0);
    wait_valid("wrap", cyc);
    chk("wrap_a0", bus.OUT_DATA, 64'd351);
    @(negedge CLK);

    // Reset mid-run, then one load lands in A[0]; A[1] = 102 and B survive: 7*3 + 102*5.
    start(16, 1'b0);
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("rst_run_out_valid", bus.OUT_VALID, 1'b0);
    chk("rst_run_busy", bus.BUSY, 1'b0);
    chk("rst_run_out_data", bus.OUT_DATA, 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    ld(1'b1, 32'd7);
    start(2, 1'b0);
    wait_valid("post_rst", cyc);
    chk("post_rst_data", bus.OUT_DATA, 64'd531);
    repeat (2) @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
